// File: rtl/sba_pkg.sv
// Shared types for the system-bus access initiator: transfer sizes, sberror codes, FSM states.
package sba_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_INVALID = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_TIMEOUT = 3'd1,
        ERR_ALIGN   = 3'd3,
        ERR_SIZE    = 3'd4
    } sberror_e;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ACCESS,
        CAPTURE,
        RESP
    } state_e;

    // Request validation done at accept time; a non-zero code skips the bus entirely.
    function automatic sberror_e check_cmd(input logic [1:0] size, input logic [1:0] offset);
        if (size == SIZE_INVALID) begin
            return ERR_SIZE;
        end
        if ((size == SIZE_HALF && offset[0]) || (size == SIZE_WORD && offset != 2'd0)) begin
            return ERR_ALIGN;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Shared arilla bus: word address, tri-state data and strobes, interceptor flag.
interface arilla_bus_if;

    wire [29:0] address;
    wire [31:0] data;
    wire [3:0]  byte_enable;
    wire        read;
    wire        write;
    wire        intercept;

    modport initiator (
        inout address,
        inout data,
        inout byte_enable,
        inout read,
        inout write,
        input intercept
    );

endinterface

// File: rtl/sba_lane_align.sv
// Byte-lane steering between LSB-aligned request data and the 32-bit bus word.
module sba_lane_align
    import sba_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] lane_wdata,
    output logic [31:0] lane_rdata
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    assign shamt      = {offset, 3'b000};
    assign lane_wdata = wdata << shamt;
    assign shifted    = bus_rdata >> shamt;

    always_comb begin
        byte_enable = 4'hF;
        lane_rdata  = shifted;
        case (size)
            SIZE_BYTE: begin
                byte_enable = 4'b0001 << offset;
                lane_rdata  = {24'b0, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_enable = 4'b0011 << offset;
                lane_rdata  = {16'b0, shifted[15:0]};
            end
            default: begin
                byte_enable = 4'hF;
                lane_rdata  = shifted;
            end
        endcase
    end

endmodule

// File: rtl/sba_master.sv
// System-bus initiator for the debug module: one debugger request becomes one arilla bus cycle.
module sba_master
    import sba_pkg::*;
#(
    parameter int unsigned GrantTimeout = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    arilla_bus_if.initiator bus_interface,
    output logic            bus_req,
    input  logic            bus_gnt,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [1:0]      cmd_size,
    input  logic [31:0]     cmd_address,
    input  logic [31:0]     cmd_wdata,
    output logic            rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic [2:0]      rsp_error
);

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    size_e       size_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic [15:0] wait_q;
    logic [31:0] rsp_rdata_q;
    sberror_e    rsp_error_q;

    logic        accept;
    logic        timeout;
    sberror_e    cmd_error;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    logic        addr_en;
    logic        strobe_en;
    logic        data_en;
    logic        read_val;
    logic        write_val;

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_error = check_cmd(cmd_size, cmd_address[1:0]);
    // Grant is tested before this, so a grant on the last counted cycle still wins.
    assign timeout   = (state_q == ARB) && !bus_gnt && (wait_q == 16'(GrantTimeout - 1));

    sba_lane_align u_lane_align (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .wdata       (wdata_q),
        .bus_rdata   (bus_interface.data),
        .byte_enable (lane_be),
        .lane_wdata  (lane_wdata),
        .lane_rdata  (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (cmd_error != ERR_NONE) ? RESP : ARB;
                end
            end
            ARB: begin
                if (bus_gnt) begin
                    state_d = ACCESS;
                end else if (timeout) begin
                    state_d = RESP;
                end
            end
            ACCESS:  state_d = write_q ? RESP : CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        bus_req   = 1'b0;
        rsp_valid = 1'b0;
        addr_en   = 1'b0;
        strobe_en = 1'b0;
        data_en   = 1'b0;
        read_val  = 1'b0;
        write_val = 1'b0;
        unique case (state_q)
            IDLE: cmd_ready = 1'b1;
            ARB:  bus_req = 1'b1;
            ACCESS: begin
                bus_req   = 1'b1;
                addr_en   = 1'b1;
                strobe_en = 1'b1;
                data_en   = write_q;
                read_val  = !write_q;
                write_val = write_q;
            end
            CAPTURE: begin
                bus_req   = 1'b1;
                strobe_en = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            size_q      <= SIZE_BYTE;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            wait_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= ERR_NONE;
        end else begin
            if (accept) begin
                addr_q      <= cmd_address;
                size_q      <= size_e'(cmd_size);
                wdata_q     <= cmd_wdata;
                write_q     <= cmd_write;
                wait_q      <= '0;
                rsp_rdata_q <= '0;
                rsp_error_q <= cmd_error;
            end
            if (state_q == ARB && !bus_gnt) begin
                wait_q <= wait_q + 16'd1;
            end
            if (timeout) begin
                rsp_error_q <= ERR_TIMEOUT;
            end
            // Responder registers its read data, so it is valid the cycle after the strobe.
            if (state_q == CAPTURE) begin
                rsp_rdata_q <= lane_rdata;
            end
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    assign bus_interface.address     = addr_en ? addr_q[31:2] : 'z;
    assign bus_interface.byte_enable = addr_en ? lane_be : 'z;
    assign bus_interface.data        = data_en ? lane_wdata : 'z;
    assign bus_interface.read        = strobe_en ? read_val : 1'bz;
    assign bus_interface.write       = strobe_en ? write_val : 1'bz;

endmodule

// File: tb/tb_sba_master.sv
// Directed bench for sba_master: bus cycles, alignment/size errors, grant timeout, mid-op reset.
module tb_sba_master;

    logic        clk;
    logic        rst_n;
    logic        bus_req;
    logic        bus_gnt;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_address;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_error;

    logic        resp_en;
    logic [31:0] resp_data;

    int checks   = 0;
    int failures = 0;

    arilla_bus_if bus ();

    assign bus.intercept = 1'b0;
    assign bus.data      = resp_en ? resp_data : 32'bz;

    sba_master #(
        .GrantTimeout (255)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_interface (bus),
        .bus_req       (bus_req),
        .bus_gnt       (bus_gnt),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_size      (cmd_size),
        .cmd_address   (cmd_address),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a request in the current idle cycle (cycle 0) and returns in cycle 1.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_size    = sz;
        cmd_address = addr;
        cmd_wdata   = wd;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        bus_gnt     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_size    = 2'd0;
        cmd_address = '0;
        cmd_wdata   = '0;
        resp_en     = 1'b0;
        resp_data   = '0;
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_read_off", 32'(bus.read === 1'b1), 32'd0);
        check("rst_write_off", 32'(bus.write === 1'b1), 32'd0);
        rst_n = 1'b1;
        tick();

        // Word write, grant already high
        issue(1'b1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF);
        check("ww_c1_bus_req", 32'(bus_req), 32'd1);
        check("ww_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("ww_c2_address", 32'(bus.address), 32'h400);
        check("ww_c2_be", 32'(bus.byte_enable), 32'hF);
        check("ww_c2_write", 32'(bus.write === 1'b1), 32'd1);
        check("ww_c2_read", 32'(bus.read === 1'b1), 32'd0);
        check("ww_c2_data", bus.data, 32'hDEAD_BEEF);
        tick();
        check("ww_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ww_c3_rsp_error", 32'(rsp_error), 32'd0);
        check("ww_c3_rsp_rdata", rsp_rdata, 32'd0);
        check("ww_c3_bus_req", 32'(bus_req), 32'd0);
        check("ww_c3_write_off", 32'(bus.write === 1'b1), 32'd0);
        tick();
        check("ww_c4_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ww_c4_cmd_ready", 32'(cmd_ready), 32'd1);

        // Byte read at offset 3
        issue(1'b0, 2'd0, 32'h0000_1003, 32'h0);
        tick();
        check("br_c2_address", 32'(bus.address), 32'h400);
        check("br_c2_be", 32'(bus.byte_enable), 32'h8);
        check("br_c2_read", 32'(bus.read === 1'b1), 32'd1);
        check("br_c2_write", 32'(bus.write === 1'b1), 32'd0);
        tick();
        check("br_c3_read_off", 32'(bus.read === 1'b1), 32'd0);
        check("br_c3_bus_req", 32'(bus_req), 32'd1);
        check("br_c3_rsp_valid", 32'(rsp_valid), 32'd0);
        resp_en   = 1'b1;
        resp_data = 32'hAABB_CCDD;
        tick();
        resp_en = 1'b0;
        check("br_c4_rsp_valid", 32'(rsp_valid), 32'd1);
        check("br_c4_rsp_rdata", rsp_rdata, 32'h0000_00AA);
        check("br_c4_rsp_error", 32'(rsp_error), 32'd0);
        tick();
        check("br_hold_rdata", rsp_rdata, 32'h0000_00AA);

        // Half write at offset 2
        issue(1'b1, 2'd1, 32'h0000_1002, 32'h0000_1234);
        tick();
        check("hw_c2_be", 32'(bus.byte_enable), 32'hC);
        check("hw_c2_data_hi", {16'h0, bus.data[31:16]}, 32'h1234);
        check("hw_c2_write", 32'(bus.write === 1'b1), 32'd1);
        tick();
        check("hw_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("hw_c3_rsp_error", 32'(rsp_error), 32'd0);
        check("hw_c3_rsp_rdata", rsp_rdata, 32'd0);
        tick();

        // Misaligned half read
        issue(1'b0, 2'd1, 32'h0000_1001, 32'h0);
        check("mis_rsp_valid", 32'(rsp_valid), 32'd1);
        check("mis_rsp_error", 32'(rsp_error), 32'd3);
        check("mis_bus_req", 32'(bus_req), 32'd0);
        check("mis_read_off", 32'(bus.read === 1'b1), 32'd0);
        tick();

        // Unsupported size
        issue(1'b0, 2'd3, 32'h0000_1000, 32'h0);
        check("sz_rsp_valid", 32'(rsp_valid), 32'd1);
        check("sz_rsp_error", 32'(rsp_error), 32'd4);
        check("sz_bus_req", 32'(bus_req), 32'd0);
        tick();

        // Grant never arrives
        bus_gnt = 1'b0;
        issue(1'b0, 2'd2, 32'h0000_3000, 32'h0);
        n = 0;
        for (int i = 0; i < 400 && !rsp_valid; i++) begin
            if (bus_req === 1'b1) n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd255);
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_error", 32'(rsp_error), 32'd1);
        check("to_bus_req", 32'(bus_req), 32'd0);
        tick();

        // Grant on the last counted cycle
        issue(1'b1, 2'd2, 32'h0000_3000, 32'h0BAD_F00D);
        repeat (254) tick();
        check("gl_c255_bus_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        tick();
        check("gl_c256_write", 32'(bus.write === 1'b1), 32'd1);
        check("gl_c256_address", 32'(bus.address), 32'hC00);
        tick();
        check("gl_c257_rsp_valid", 32'(rsp_valid), 32'd1);
        check("gl_c257_rsp_error", 32'(rsp_error), 32'd0);
        tick();

        // Reset during arbitration
        bus_gnt = 1'b0;
        issue(1'b0, 2'd2, 32'h0000_2000, 32'h0);
        check("ra_in_arb", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        tick();
        check("ra_bus_req", 32'(bus_req), 32'd0);
        check("ra_cmd_ready", 32'(cmd_ready), 32'd1);
        check("ra_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n   = 1'b1;
        bus_gnt = 1'b1;
        tick();
        check("ra_after_rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset during capture
        issue(1'b0, 2'd2, 32'h0000_2000, 32'h0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("rc_bus_req", 32'(bus_req), 32'd0);
        check("rc_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rc_read_off", 32'(bus.read === 1'b1), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rc_after_rsp_valid", 32'(rsp_valid), 32'd0);

        // Word read completes normally after reset
        issue(1'b0, 2'd2, 32'h0000_2004, 32'h0);
        tick();
        check("wr_c2_address", 32'(bus.address), 32'h801);
        check("wr_c2_read", 32'(bus.read === 1'b1), 32'd1);
        tick();
        resp_en   = 1'b1;
        resp_data = 32'h8765_4321;
        tick();
        resp_en = 1'b0;
        check("wr_c4_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_c4_rsp_rdata", rsp_rdata, 32'h8765_4321);
        check("wr_c4_rsp_error", 32'(rsp_error), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
